video_clk_gen: RTL and testbench

Parametrised, fully digital successor to the fixed two-output video clock PLL. Generates NUM_CLKS independent clock outputs from `refclk` using per-channel phase accumulators (DDS-style fractional dividers), each with a matching single-cycle clock-enable pulse. Channel frequencies are reprogrammable at run time through a valid/ready port. A settle counter drives `locked`, which mimics PLL lock behaviour so downstream video timing logic can stay unchanged.

---
 rtl/video_clk_gen.sv | 133 +++++++++++++
 tb/tb_video_clk_gen.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_clk_gen.sv
// video_clk_gen
// -----------------------------------------------------------------------------
// Fully digital multi-output video clock generator. Each channel owns a phase
// accumulator that adds its increment on every refclk edge; the accumulator MSB
// is the generated clock and a one-cycle enable marks each rising edge of it.
// A settle counter emulates PLL lock: after reset or any reconfiguration the
// block sits in SETTLE for LOCK_CYCLES edges with everything quiet, then RUNs.
//
// Handshake: a reconfiguration transfers on a rising refclk edge where
// cfg_valid and cfg_ready are both high. cfg_ready is high exactly in RUN.
// The requester keeps cfg_valid, cfg_sel and cfg_inc stable until that edge.
// A transfer to a nonexistent channel completes without any effect.
//
// Ports
//   refclk     in   reference clock, all logic on its rising edge
//   rst        in   synchronous active-high reset
//   cfg_valid  in   reconfiguration request
//   cfg_ready  out  high only in RUN
//   cfg_sel    in   target channel
//   cfg_inc    in   new increment, f_out = cfg_inc / 2^ACC_W * f_refclk
//   outclk     out  generated clocks (MSB of each accumulator)
//   outclk_en  out  one-cycle pulse on each rising edge of outclk[i]
//   locked     out  high only in RUN
//   fsm_state  out  current controller state (0 = SETTLE, 1 = RUN)
// -----------------------------------------------------------------------------
module video_clk_gen #(
    parameter int NUM_CLKS    = 2,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 1024,
    parameter logic [NUM_CLKS*ACC_W-1:0] INC_INIT = {32'h80000000, 32'h66666666},
    localparam int SEL_W      = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1
) (
    input  logic                refclk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [SEL_W-1:0]    cfg_sel,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [NUM_CLKS-1:0] outclk,
    output logic [NUM_CLKS-1:0] outclk_en,
    output logic                locked,
    output logic                fsm_state
);

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    localparam int CNT_W = $clog2(LOCK_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    // Half the reference rate is the fastest clock an accumulator MSB can make.
    localparam logic [ACC_W-1:0] INC_MAX = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [SEL_W:0]   NUM_SEL = NUM_CLKS[SEL_W:0];

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ACC_W-1:0]  inc      [NUM_CLKS];
    logic [ACC_W-1:0]  acc      [NUM_CLKS];
    logic              prev_msb [NUM_CLKS];

    logic              sel_hit;
    logic [ACC_W-1:0]  inc_clamped;

    // Out-of-range selects still complete the handshake but change nothing.
    assign sel_hit     = ({1'b0, cfg_sel} < NUM_SEL);
    assign inc_clamped = (cfg_inc > INC_MAX) ? INC_MAX : cfg_inc;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= SETTLE;
            cnt   <= '0;
            for (int i = 0; i < NUM_CLKS; i++) begin
                inc[i]      <= INC_INIT[i*ACC_W +: ACC_W];
                acc[i]      <= '0;
                prev_msb[i] <= 1'b0;
            end
        end else begin
            case (state)
                SETTLE: begin
                    for (int i = 0; i < NUM_CLKS; i++) begin
                        acc[i]      <= '0;
                        prev_msb[i] <= 1'b0;
                    end
                    if (cnt == CNT_LAST) begin
                        state <= RUN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (cfg_valid && sel_hit) begin
                        // Clearing every accumulator re-aligns all channel phases.
                        for (int i = 0; i < NUM_CLKS; i++) begin
                            if (cfg_sel == SEL_W'(i)) begin
                                inc[i] <= inc_clamped;
                            end
                            acc[i]      <= '0;
                            prev_msb[i] <= 1'b0;
                        end
                        state <= SETTLE;
                        cnt   <= '0;
                    end else begin
                        for (int i = 0; i < NUM_CLKS; i++) begin
                            acc[i]      <= acc[i] + inc[i];
                            prev_msb[i] <= acc[i][ACC_W-1];
                        end
                    end
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Pure decode of registers, so the outputs cannot glitch.
    always_comb begin
        outclk    = '0;
        outclk_en = '0;
        for (int i = 0; i < NUM_CLKS; i++) begin
            outclk[i]    = acc[i][ACC_W-1];
            outclk_en[i] = acc[i][ACC_W-1] & ~prev_msb[i];
        end
    end

    assign cfg_ready = (state == RUN);
    assign locked    = (state == RUN);
    assign fsm_state = state;

endmodule

// File: tb/tb_video_clk_gen.sv
// Bench for video_clk_gen with three channels and a 16-edge settle time.
// Channel 0 starts at 0.4 of refclk, channel 1 at 0.5, channel 2 at 0.25.
module tb_video_clk_gen;

    localparam int NCH  = 3;
    localparam int LOCK = 16;
    localparam int W    = 9;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] inc;
        int          c0;
        int          c1;
        int          c2;
        logic [7:0]  p0;
        logic [7:0]  p1;
    } vec_t;

    // ---------------- clock / reset / DUT ----------------
    logic           refclk = 1'b0;
    logic           rst;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [1:0]     cfg_sel;
    logic [31:0]    cfg_inc;
    logic [NCH-1:0] outclk;
    logic [NCH-1:0] outclk_en;
    logic           locked;
    logic           fsm_state;

    always #5 refclk = ~refclk;

    video_clk_gen #(
        .NUM_CLKS    (NCH),
        .ACC_W       (32),
        .LOCK_CYCLES (LOCK),
        .INC_INIT    ({32'h40000000, 32'h80000000, 32'h66666666})
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_sel   (cfg_sel),
        .cfg_inc   (cfg_inc),
        .outclk    (outclk),
        .outclk_en (outclk_en),
        .locked    (locked),
        .fsm_state (fsm_state)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    logic [NCH-1:0] s_clk;
    logic [NCH-1:0] s_en;
    logic           s_locked;
    logic           s_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [31:0] m_inc  [NCH];
    logic [31:0] m_acc  [NCH];
    logic        m_prev [NCH];
    logic        m_run;
    int          m_settle;

    function automatic void model_edge();
        if (rst) begin
            m_inc[0] = 32'h66666666;
            m_inc[1] = 32'h80000000;
            m_inc[2] = 32'h40000000;
            for (int i = 0; i < NCH; i++) begin
                m_acc[i]  = '0;
                m_prev[i] = 1'b0;
            end
            m_run    = 1'b0;
            m_settle = 0;
        end else if (!m_run) begin
            m_settle++;
            if (m_settle == LOCK) begin
                m_run    = 1'b1;
                m_settle = 0;
            end
        end else if (cfg_valid && int'(cfg_sel) < NCH) begin
            m_inc[cfg_sel] = (cfg_inc > 32'h80000000) ? 32'h80000000 : cfg_inc;
            for (int i = 0; i < NCH; i++) begin
                m_acc[i]  = '0;
                m_prev[i] = 1'b0;
            end
            m_run    = 1'b0;
            m_settle = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                m_prev[i] = m_acc[i][31];
                m_acc[i]  = m_acc[i] + m_inc[i];
            end
        end
    endfunction

    function automatic logic [W-1:0] model_out();
        logic [NCH-1:0] c;
        logic [NCH-1:0] e;
        for (int i = 0; i < NCH; i++) begin
            c[i] = m_acc[i][31];
            e[i] = m_acc[i][31] & ~m_prev[i];
        end
        return {m_run, m_run, m_run, c, e};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a falling edge with inputs already set: predict, clock, compare.
    task automatic tick();
        logic [W-1:0] act;
        logic [W-1:0] exp;
        model_edge();
        exp_q.push_back(model_out());
        @(posedge refclk);
        #1;
        act = {fsm_state, locked, cfg_ready, outclk, outclk_en};
        s_clk    = outclk;
        s_en     = outclk_en;
        s_locked = locked;
        s_ready  = cfg_ready;
        if (exp_q.size() == 0) begin
            check("cycle_queue_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("cycle", 32'(act), 32'(exp));
        end
        @(negedge refclk);
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_locked && n < 100);
    endtask

    task automatic do_cfg(input logic [1:0] sel, input logic [31:0] inc, output int ticks);
        logic was_ready;
        cfg_sel   = sel;
        cfg_inc   = inc;
        cfg_valid = 1'b1;
        ticks     = 0;
        do begin
            was_ready = cfg_ready;
            tick();
            ticks++;
        end while (!was_ready && ticks < 100);
        cfg_valid = 1'b0;
    endtask

    task automatic run_count(input int n, output int c0, output int c1, output int c2,
                             output logic [15:0] pe0, output logic [7:0] p0,
                             output logic [7:0] p1);
        c0 = 0; c1 = 0; c2 = 0;
        pe0 = '0; p0 = '0; p1 = '0;
        for (int k = 0; k < n; k++) begin
            tick();
            c0 += int'(s_en[0]);
            c1 += int'(s_en[1]);
            c2 += int'(s_en[2]);
            if (k < 16) pe0[k] = s_en[0];
            if (k < 8) begin
                p0[k] = s_clk[0];
                p1[k] = s_clk[1];
            end
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [6];

    initial begin
        int n;
        int c0, c1, c2;
        logic [15:0] pe0;
        logic [7:0]  p0, p1;

        vecs[0] = '{2'd1, 32'h40000000, 160, 100, 100, 8'h5A, 8'h66};
        vecs[1] = '{2'd0, 32'hFFFFFFFF, 200, 100, 100, 8'h55, 8'h66};
        vecs[2] = '{2'd0, 32'h00000000,   0, 100, 100, 8'h00, 8'h66};
        vecs[3] = '{2'd2, 32'h20000000,   0, 100,  50, 8'h00, 8'h66};
        vecs[4] = '{2'd1, 32'h80000001,   0, 200,  50, 8'h00, 8'h55};
        vecs[5] = '{2'd0, 32'h55555555, 133, 200,  50, 8'hB6, 8'h55};

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_sel   = '0;
        cfg_inc   = '0;
        @(negedge refclk);
        tick();
        tick();
        check("reset_outputs", 32'({s_locked, s_ready, s_clk, s_en}), 32'd0);

        // Lock after reset
        rst = 1'b0;
        wait_lock(n);
        check("lock_edges_after_reset", 32'(n), 32'(LOCK));
        check("ready_with_lock", 32'(s_ready), 32'd1);

        // Reset frequencies
        run_count(500, c0, c1, c2, pe0, p0, p1);
        check("init_pulses_ch0", 32'(c0), 32'd200);
        check("init_pulses_ch1", 32'(c1), 32'd250);
        check("init_pulses_ch2", 32'(c2), 32'd125);
        check("init_en0_pattern", 32'(pe0), 32'h294A);
        check("init_clk0_pattern", 32'(p0), 32'h5A);
        check("init_clk1_pattern", 32'(p1), 32'h55);

        // Reconfiguration table
        for (int v = 0; v < 6; v++) begin
            do_cfg(vecs[v].sel, vecs[v].inc, n);
            check($sformatf("v%0d_accept_ticks", v), 32'(n), 32'd1);
            check($sformatf("v%0d_lock_drop", v), 32'(s_locked), 32'd0);
            wait_lock(n);
            check($sformatf("v%0d_relock_edges", v), 32'(n), 32'(LOCK));
            run_count(400, c0, c1, c2, pe0, p0, p1);
            check($sformatf("v%0d_pulses_ch0", v), 32'(c0), 32'(vecs[v].c0));
            check($sformatf("v%0d_pulses_ch1", v), 32'(c1), 32'(vecs[v].c1));
            check($sformatf("v%0d_pulses_ch2", v), 32'(c2), 32'(vecs[v].c2));
            check($sformatf("v%0d_clk0_pattern", v), 32'(p0), 32'(vecs[v].p0));
            check($sformatf("v%0d_clk1_pattern", v), 32'(p1), 32'(vecs[v].p1));
        end

        // Nonexistent channel: handshake completes, nothing changes
        do_cfg(2'd3, 32'h12345678, n);
        check("oor_accept_ticks", 32'(n), 32'd1);
        check("oor_locked", 32'(s_locked), 32'd1);
        check("oor_ready", 32'(s_ready), 32'd1);
        for (int k = 0; k < 20; k++) tick();

        // Request held through SETTLE is taken on the first RUN edge
        do_cfg(2'd0, 32'h80000000, n);
        check("hold_first_ticks", 32'(n), 32'd1);
        do_cfg(2'd1, 32'h20000000, n);
        check("hold_second_ticks", 32'(n), 32'(LOCK + 1));
        check("hold_lock_drop", 32'(s_locked), 32'd0);
        wait_lock(n);
        check("hold_relock_edges", 32'(n), 32'(LOCK));
        run_count(400, c0, c1, c2, pe0, p0, p1);
        check("hold_pulses_ch0", 32'(c0), 32'd200);
        check("hold_pulses_ch1", 32'(c1), 32'd50);
        check("hold_pulses_ch2", 32'(c2), 32'd50);

        // Reset during RUN
        for (int k = 0; k < 7; k++) tick();
        rst = 1'b1;
        tick();
        check("midrst_outputs", 32'({s_locked, s_ready, s_clk, s_en}), 32'd0);
        rst = 1'b0;
        wait_lock(n);
        check("midrst_relock_edges", 32'(n), 32'(LOCK));
        run_count(500, c0, c1, c2, pe0, p0, p1);
        check("midrst_pulses_ch0", 32'(c0), 32'd200);
        check("midrst_pulses_ch1", 32'(c1), 32'd250);
        check("midrst_pulses_ch2", 32'(c2), 32'd125);

        // Reset on the same edge as an otherwise valid handshake
        cfg_sel   = 2'd0;
        cfg_inc   = 32'h00000000;
        cfg_valid = 1'b1;
        rst       = 1'b1;
        tick();
        check("rstcfg_outputs", 32'({s_locked, s_ready, s_clk, s_en}), 32'd0);
        rst       = 1'b0;
        cfg_valid = 1'b0;
        wait_lock(n);
        check("rstcfg_relock_edges", 32'(n), 32'(LOCK));
        run_count(500, c0, c1, c2, pe0, p0, p1);
        check("rstcfg_pulses_ch0", 32'(c0), 32'd200);
        check("rstcfg_pulses_ch1", 32'(c1), 32'd250);
        check("rstcfg_pulses_ch2", 32'(c2), 32'd125);

        check("queue_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
